// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave side; the host/memory environment takes master.
interface mips32_prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader: receives length header, big-endian instruction words and an XOR
// checksum, writes the words from address 0 and holds the core until verified.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start, core held
// LEN_HI | waiting for length byte [15:8]
// LEN_LO | waiting for length byte [7:0], length range checked here
// DATA   | assembling words; one memory write per completed word
// CSUM   | waiting for checksum byte
// DONE   | image verified, core released
// ERR    | bad length or checksum, core held, err sticky
module mips32_prog_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 start,
   mips32_prog_loader_if.slave  bus,
   output logic                 core_hold,
   output logic                 done,
   output logic [1:0]           err,
   output logic [ADDR_W:0]      words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [15:0] DEPTH16  = 16'(DEPTH);
   localparam logic [1:0]  ERR_NONE = 2'b00;
   localparam logic [1:0]  ERR_LEN  = 2'b01;
   localparam logic [1:0]  ERR_CSUM = 2'b10;

   state_t            state_q, state_d;
   logic [7:0]        len_hi_q;
   logic [ADDR_W:0]   length_q;
   logic [7:0]        csum_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       word_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic              ready;
   logic              take;
   logic              start_ok;
   logic              len_bad;
   logic              word_done;
   logic              csum_ok;
   logic [15:0]       len_new;

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ready     = 1'b0;
      take      = 1'b0;
      start_ok  = 1'b0;
      len_bad   = 1'b0;
      word_done = 1'b0;
      csum_ok   = 1'b0;
      len_new   = {len_hi_q, bus.in_data};

      unique case (state_q)
         S_LEN_HI, S_LEN_LO, S_CSUM: ready = 1'b1;
         // a completed word blocks the stream for its write cycle
         S_DATA:                     ready = !mem_we_q;
         default:                    ready = 1'b0;
      endcase

      take    = bus.in_valid && ready;
      len_bad = (len_new == 16'd0) || (len_new > DEPTH16);
      csum_ok = (csum_q == bus.in_data);

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               start_ok = 1'b1;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (take) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (take) state_d = len_bad ? S_ERR : S_DATA;
         end
         S_DATA: begin
            word_done = take && (byte_idx_q == 2'd3);
            if (mem_we_q && (words_loaded == length_q)) state_d = S_CSUM;
         end
         S_CSUM: begin
            if (take) state_d = csum_ok ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_q     <= '0;
         length_q     <= '0;
         csum_q       <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         core_hold    <= 1'b1;
         done         <= 1'b0;
         err          <= ERR_NONE;
         words_loaded <= '0;
      end else begin
         done     <= 1'b0;
         mem_we_q <= 1'b0;

         if (start_ok) begin
            core_hold    <= 1'b1;
            err          <= ERR_NONE;
            words_loaded <= '0;
            csum_q       <= '0;
            byte_idx_q   <= '0;
         end

         if (take) begin
            unique case (state_q)
               S_LEN_HI: len_hi_q <= bus.in_data;
               S_LEN_LO: begin
                  length_q <= len_new[ADDR_W:0];
                  if (len_bad) err <= ERR_LEN;
               end
               S_DATA: begin
                  csum_q     <= csum_q ^ bus.in_data;
                  word_q     <= {word_q[15:0], bus.in_data};
                  byte_idx_q <= byte_idx_q + 2'd1;
               end
               S_CSUM: begin
                  if (csum_ok) begin
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                  end else begin
                     err <= ERR_CSUM;
                  end
               end
               default: ;
            endcase
         end

         // address is the pre-increment count, so the last legal word lands at DEPTH-1
         if (word_done) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= words_loaded[ADDR_W-1:0];
            mem_wdata_q  <= {word_q, bus.in_data};
            words_loaded <= words_loaded + 1'b1;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
